// File: rtl/sw_debounce.sv
// Switch/button input conditioner: two-flop synchroniser, per-bit stability
// counter, and registered rise/fall/any_change pulses on every accepted edge.
module sw_debounce #(
  parameter int WIDTH   = 3,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = $clog2(CNT_MAX)
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            s1;
  logic [WIDTH-1:0]            s2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]            db_nxt;
  logic [WIDTH-1:0]            rise_nxt;
  logic [WIDTH-1:0]            fall_nxt;

  // A bit is COUNTING while cnt != 0; any sample of s2 matching sw_db drops
  // it back to IDLE, so only an unbroken run of CNT_MAX cycles is accepted.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
    db_nxt   = sw_db;
    rise_nxt = '0;
    fall_nxt = '0;
    cnt_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2[i] != sw_db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_nxt[i]   = s2[i];
          rise_nxt[i] = s2[i];
          fall_nxt[i] = ~s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      s1         <= '0;
      s2         <= '0;
      // NOTE: the counters are ordinary flops, not a RAM, so they take the reset like any other state.
      cnt        <= '0;
      sw_db      <= '0;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      s1         <= sw_raw;
      s2         <= s1;
      cnt        <= cnt_nxt;
      sw_db      <= db_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      any_change <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: stimulus pushes the expected output event into
// a scoreboard; a negedge monitor pops it on its cycle and checks idle cycles otherwise.
module tb_sw_debounce;

  localparam int WIDTH   = 3;
  localparam int CNT_MAX = 4;
  localparam int LAT     = CNT_MAX + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_change;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH  (WIDTH),
    .CNT_MAX(CNT_MAX)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .sw_raw    (sw_raw),
    .sw_db     (sw_db),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  typedef struct {
    int               at_cyc;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  int               cyc       = 0;
  int               checks    = 0;
  int               errors    = 0;
  bit               mon_en    = 1'b0;
  logic [WIDTH-1:0] exp_level = '0;

  task automatic check(input string tag, input string field,
                       input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s cyc=%0d observed=%b expected=%b", tag, field, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // The new sw_db level, with its one-cycle pulses, is due LAT edges after the drive.
  task automatic push_exp(input string tag, input logic [WIDTH-1:0] db,
                          input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f);
    exp_t e;
    e.at_cyc = cyc + LAT;
    e.db     = db;
    e.rise   = r;
    e.fall   = f;
    e.any    = |(r | f);
    e.tag    = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].at_cyc == cyc) begin
        e = sb.pop_front();
        check(e.tag, "sw_db", sw_db, e.db);
        check(e.tag, "rise",  rise,  e.rise);
        check(e.tag, "fall",  fall,  e.fall);
        check(e.tag, "any",   {{(WIDTH-1){1'b0}}, any_change}, {{(WIDTH-1){1'b0}}, e.any});
        exp_level = e.db;
      end else begin
        check("idle", "sw_db", sw_db, exp_level);
        check("idle", "rise",  rise,  '0);
        check("idle", "fall",  fall,  '0);
        check("idle", "any",   {{(WIDTH-1){1'b0}}, any_change}, '0);
      end
    end
  end

  initial begin
    // Reset held with all pins high: outputs stay 0, then a normal rise follows release.
    rst    = 1'b1;
    sw_raw = 3'b111;
    tick();
    mon_en = 1'b1;
    ticks(2);
    rst = 1'b0;
    push_exp("reset_rise", 3'b111, 3'b111, 3'b000);
    ticks(7);
    sw_raw = 3'b000;
    push_exp("reset_fall", 3'b000, 3'b000, 3'b111);
    ticks(8);

    // Clean single-bit edge in each direction.
    sw_raw = 3'b001;
    push_exp("clean_rise", 3'b001, 3'b001, 3'b000);
    ticks(8);
    sw_raw = 3'b000;
    push_exp("clean_fall", 3'b000, 3'b000, 3'b001);
    ticks(8);

    // A 3-cycle pulse is one short of acceptance; a 4-cycle pulse is accepted.
    sw_raw = 3'b010;
    ticks(3);
    sw_raw = 3'b000;
    ticks(8);
    sw_raw = 3'b010;
    push_exp("pulse4_rise", 3'b010, 3'b010, 3'b000);
    ticks(4);
    sw_raw = 3'b000;
    push_exp("pulse4_fall", 3'b000, 3'b000, 3'b010);
    ticks(8);

    // Bounce 1,0,1,0,1 then hold: a single rise timed from the last transition.
    sw_raw = 3'b100; tick();
    sw_raw = 3'b000; tick();
    sw_raw = 3'b100; tick();
    sw_raw = 3'b000; tick();
    sw_raw = 3'b100;
    push_exp("bounce_rise", 3'b100, 3'b100, 3'b000);
    ticks(8);
    sw_raw = 3'b000;
    push_exp("bounce_fall", 3'b000, 3'b000, 3'b100);
    ticks(8);

    // Bits 0 and 2 change together while bit 1 chatters every cycle.
    sw_raw = 3'b101;
    push_exp("simul_rise", 3'b101, 3'b101, 3'b000);
    for (int i = 0; i < 12; i++) begin
      tick();
      sw_raw[1] = ~sw_raw[1];
    end
    sw_raw = 3'b101;
    ticks(4);
    sw_raw = 3'b000;
    push_exp("simul_fall", 3'b000, 3'b000, 3'b101);
    ticks(8);

    // Reset on the third counting edge discards the count; acceptance restarts.
    sw_raw = 3'b001;
    ticks(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_exp("midrst_rise", 3'b001, 3'b001, 3'b000);
    ticks(8);

    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain pending observed=%0d expected=0", sb.size());
    end
    ticks(3);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side conditioner for the board's slide switches and push-buttons.
- Synchronises each raw pin to CLK100MHZ and debounces it with a per-bit stability counter.
- Outputs clean levels plus one-cycle rise/fall pulses for downstream logic (gate demos, counters, LED drivers).
- Instantiated once in the top level, between the SW/BTN pins and all consuming logic; nothing reads raw pins directly.

Parameters:
- WIDTH, 3: number of independent input bits.
- CNT_MAX, 1000000: consecutive stable cycles required before accepting a new level (10 ms at 100 MHz). Legal range is CNT_MAX >= 2.
- CNT_W, $clog2(CNT_MAX): stability counter width per bit.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz; all state on rising edge.
- RST  input  1  synchronous reset, active-high.
- sw_raw  input  WIDTH  asynchronous raw switch/button pins.
- sw_db  output  WIDTH  debounced level, registered.
- rise  output  WIDTH  one-cycle pulse when the sw_db bit goes 0->1.
- fall  output  WIDTH  one-cycle pulse when the sw_db bit goes 1->0.
- any_change  output  1  OR of all rise/fall bits; one-cycle pulse.

Behaviour:
- Interface: one clock, CLK100MHZ. Reset RST is synchronous and active-high. No other clock or reset.
- Reset (RST=1 at a rising edge): s1, s2, sw_db, all counters, rise, fall and any_change become 0. RST has priority over all other logic.
- Reset mid-count discards partial counts. A pin held at 1 through reset produces a normal debounced rise after reset releases.
- Synchroniser, per bit: s1 <= sw_raw; s2 <= s1. Only s2 feeds the debounce logic. sw_raw is never used combinationally.
- Debounce, per bit, independent of the other bits. Each bit has states IDLE (cnt==0) and COUNTING (cnt>0):
  - If s2 == sw_db: cnt <= 0.
  - Else if cnt == CNT_MAX-1: sw_db <= s2, cnt <= 0, and the matching rise or fall bit is asserted for exactly this one cycle.
  - Else: cnt <= cnt+1.
- Glitch rejection: any cycle in which s2 returns to the sw_db value clears cnt. Pulses shorter than CNT_MAX cycles at s2 never change sw_db.
- Latency: if sw_raw changes and stays stable, sw_db changes CNT_MAX+2 rising edges after the edge that first samples the new value. That is 2 edges of synchroniser plus CNT_MAX edges of counting.
- rise, fall and any_change are registered. They go high in the same cycle sw_db changes and return to 0 the next cycle unless another bit changes.
- rise[i] and fall[i] are never both high.
- Simultaneous changes on several bits produce simultaneous pulses. any_change is high for a single cycle.
- The counter saturates by construction (cleared at CNT_MAX-1). No wrap-around is possible.
- Bounce after acceptance starts a new count from 0. No immediate re-toggle.

Test Plan (CNT_MAX=4, WIDTH=3 unless stated):
- Reset: drive sw_raw=3'b111 with RST=1 for 3 cycles -> sw_db=000, rise=fall=000 throughout. Release RST -> sw_db=111 exactly 6 edges later, with rise=111 and any_change=1 for one cycle only.
- Clean edge: from steady state sw_db=000, set sw_raw[0]=1 at edge k -> sw_db[0]=1 after edge k+6, rise[0]=1 in that cycle only, fall=000.
- Glitch: from sw_db=000, pulse sw_raw[1]=1 for 3 cycles then 0 -> sw_db stays 000, no rise/fall pulses. A 4-cycle pulse -> rise[1], followed later by fall[1] (6 edges after the return to 0).
- Bounce: toggle sw_raw[2] 1,0,1,0,1 on successive cycles, then hold at 1 -> exactly one rise[2], 6 edges after the last transition is sampled.
- Simultaneous and independent: at the same edge set sw_raw 000->101 -> rise=101 and any_change=1 in the same single cycle. Meanwhile bit 1 toggling with period 2 never changes sw_db[1].
- Reset mid-count: sw_raw[0] 0->1, assert RST on the 3rd counting cycle for 1 cycle -> no rise. rise[0] occurs 6 edges after RST deasserts; sw_db=001.
